apb_mem_slave: RTL
==================

# apb_mem_slave

- APB3 completer: word-addressed memory with a parameterised number of wait states and optional error signalling.
- Sits directly downstream of the AHB3-Lite-to-APB bridge.
- Consumes the bridge's APB requester signals and returns PRDATA/PREADY/PSLVERR.
- Serves as the reference target for bridge verification and as a generic peripheral-register backing store.

## Interface
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width (byte lanes = DATA_WIDTH/8)
- DEPTH, 256, number of DATA_WIDTH words
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- WAIT_CYCLES, 2, PREADY-low access cycles inserted per transfer (0 = zero-wait)

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- PSEL  in  1  select
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data, registered
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error response, valid only with PREADY

## Operation
- Decode:
  - off = PADDR - BASE_ADDR
  - idx = off >> log2(DATA_WIDTH/8)
  - in_range = (PADDR >= BASE_ADDR) && (idx < DEPTH)
  - aligned = low byte-offset bits of PADDR are zero
- FSM states: IDLE, ACCESS.
- IDLE:
  - On PSEL=1 && PENABLE=0 (setup phase): latch idx, PWRITE, decode result; load cnt = WAIT_CYCLES; go to ACCESS.
  - On the same edge, for a valid read, PRDATA <= mem[idx]; for an invalid read, PRDATA <= 0.
- ACCESS:
  - PREADY = (cnt == 0), combinational from registered state.
  - Each ACCESS cycle with PSEL && PENABLE && cnt != 0: cnt decrements.
  - On the cycle with PREADY=1: a valid write commits mem[idx] <= PWDATA at the closing edge; FSM returns to IDLE.
  - If PSEL drops while in ACCESS (protocol violation): abort to IDLE, no write, no PREADY pulse.
- Back-to-back: the cycle after completion is sampled in IDLE, so a new setup phase starts with no dead cycle. Each transfer takes exactly 2 + WAIT_CYCLES cycles.
- PRDATA holds its value until the next read setup. Writes never alter PRDATA.
- Memory contents are not reset. Reset clears only control state.

## Timing
- Reset values: FSM=IDLE, cnt=0, PRDATA=0, PREADY=0, PSLVERR=0.
- PRESET sampled on the PCLK rising edge. A reset mid-transfer discards the pending write and returns to IDLE on that edge.
- Read latency: data valid from the first ACCESS cycle; PREADY rises WAIT_CYCLES cycles after PENABLE rises.
- Write is visible to a read whose setup phase is on the cycle immediately after the write's PREADY cycle.
- PREADY is high for exactly one cycle per transfer.
- PREADY is never high in IDLE.
- PSLVERR is 0 whenever PREADY is 0.
- Registered outputs: PRDATA, and the state/cnt registers feeding PREADY and PSLVERR. There is no combinational path from PADDR/PWDATA to any output.

## Configuration
- APB_MEM_SLAVE_PSLVERR_EN defined:
  - An invalid access (not in_range, or not aligned) completes with normal wait states and PSLVERR=1 on the PREADY cycle.
  - Write suppressed; PRDATA=0.
- APB_MEM_SLAVE_PSLVERR_EN undefined:
  - PSLVERR is tied to 0.
  - Out-of-range writes are silently dropped; out-of-range reads return 0.
  - Low address bits are ignored, so an unaligned access hits word idx.

## Test plan
- Reset: assert PRESET for 2 cycles mid-write to addr 0x10 -> PREADY=0, PRDATA=0 after reset; a subsequent read of 0x10 does not return the aborted PWDATA.
- WAIT_CYCLES=2: write 0xDEADBEEF to 0x04, then read 0x04 -> each transfer takes 4 cycles with PREADY high only in the 4th; PRDATA=0xDEADBEEF.
- WAIT_CYCLES=0: back-to-back writes to 0x00..0x3C with data = address, then reads -> 2 cycles per transfer, no idle cycles, all 16 values match.
- Boundary, DEPTH=256, BASE=0: read 0x3FC -> valid, PSLVERR=0. Read 0x400 -> PRDATA=0, and PSLVERR=1 only with the macro defined.
- Unaligned write to 0x0000_0006 with the macro -> PSLVERR=1 and mem[1] unchanged. Without the macro -> mem[1] written.
- PSEL deasserted during wait state of a write to 0x08 -> no PREADY pulse, mem[2] unchanged, next setup accepted normally.

Source files
------------

// File: rtl/apb_mem_slave_if.sv
// APB3 requester/completer signal bundle for apb_mem_slave.
interface apb_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB3 word-addressed memory completer with fixed wait states.
// Optional error response enabled by defining APB_MEM_SLAVE_PSLVERR_EN.
module apb_mem_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 2
) (
  input logic            PCLK,
  input logic            PRESET,
  apb_mem_slave_if.slave apb
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx_q;
  logic                  wr_q;
  logic                  ok_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] idx_full;
  logic                  in_range;
  logic                  ok;
  logic                  setup;
  logic                  ready;
  logic                  commit;

  always_comb begin
    off      = apb.PADDR - BASE_ADDR;
    idx_full = off >> LSB;
    in_range = (apb.PADDR >= BASE_ADDR) && (idx_full < ADDR_WIDTH'(DEPTH));
`ifdef APB_MEM_SLAVE_PSLVERR_EN
    ok       = in_range && ((apb.PADDR & ADDR_WIDTH'(BYTES - 1)) == '0);
`else
    // low byte-offset bits are ignored: an unaligned access hits its word
    ok       = in_range;
`endif
  end

  assign setup  = apb.PSEL && !apb.PENABLE;
  assign ready  = (state == ACCESS) && (cnt == '0);
  assign commit = ready && apb.PSEL && apb.PENABLE && wr_q && ok_q && !PRESET;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      ok_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            state <= ACCESS;
            cnt   <= CW'(WAIT_CYCLES);
            idx_q <= idx_full[IW-1:0];
            wr_q  <= apb.PWRITE;
            ok_q  <= ok;
            // read data is fetched at setup so it is valid from the first access cycle
            if (!apb.PWRITE) rdata_q <= ok ? mem[idx_full[IW-1:0]] : '0;
          end
        end
        ACCESS: begin
          if (!apb.PSEL)            state <= IDLE;
          else if (cnt == '0)       state <= IDLE;
          else if (apb.PENABLE)     cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge PCLK) begin
    if (commit) mem[idx_q] <= apb.PWDATA;
  end

  assign apb.PRDATA = rdata_q;
  assign apb.PREADY = ready;
`ifdef APB_MEM_SLAVE_PSLVERR_EN
  assign apb.PSLVERR = ready && !ok_q;
`else
  assign apb.PSLVERR = 1'b0;
`endif
endmodule
